// File: rtl/dmem_pkg.sv
// Shared types and defaults for the burst data memory.
// Parity helper is only referenced when DMEM_PARITY_EN is defined.
package dmem_pkg;
  localparam int DMEM_DATA_W    = 16;
  localparam int DMEM_ADDR_W    = 16;
  localparam int DMEM_DEPTH     = 256;
  localparam int DMEM_MAX_BURST = 8;
  localparam int DMEM_PAR_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } dmem_state_t;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DMEM_PAR_MAX_W-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/dmem_ram_array.sv
// Word storage: one synchronous write port, one registered read port.
// With DMEM_PARITY_EN defined, each word carries an even-parity bit checked on read.
module dmem_ram_array
  import dmem_pkg::*;
#(
  parameter  int DATA_W = DMEM_DATA_W,
  parameter  int DEPTH  = DMEM_DEPTH,
  localparam int IDX_W  = $clog2(DEPTH)
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_par_err
);
`ifdef DMEM_PARITY_EN
  localparam int W = DATA_W + 1;
`else
  localparam int W = DATA_W;
`endif

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
`ifdef DMEM_PARITY_EN
      mem[waddr] <= {even_parity(DMEM_PAR_MAX_W'(wdata)), wdata};
`else
      mem[waddr] <= wdata;
`endif
    end
  end

  // rd_data only updates on a read beat, so it holds between bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data    <= '0;
      rd_par_err <= 1'b0;
    end else begin
      rd_par_err <= 1'b0;
      if (re) begin
        rd_data <= mem[raddr][DATA_W-1:0];
`ifdef DMEM_PARITY_EN
        rd_par_err <= ^mem[raddr];
`endif
      end
    end
  end
endmodule

// File: rtl/data_memory_burst.sv
// Burst data memory for LM/SM: valid/ready request channel, 1..MAX_BURST beats.
// Optional parity storage/check selected by DMEM_PARITY_EN.
module data_memory_burst
  import dmem_pkg::*;
#(
  parameter  int DATA_W    = DMEM_DATA_W,
  parameter  int ADDR_W    = DMEM_ADDR_W,
  parameter  int DEPTH     = DMEM_DEPTH,
  parameter  int MAX_BURST = DMEM_MAX_BURST,
  localparam int IDX_W     = $clog2(DEPTH),
  localparam int LEN_W     = $clog2(MAX_BURST + 1)
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              busy,
  output logic              err,
  output logic              rd_par_err
);
  dmem_state_t      state, state_nx;
  logic [IDX_W-1:0] ptr, ptr_nx;
  logic [LEN_W-1:0] cnt, cnt_nx;
  logic             rd_valid_nx, rd_last_nx, err_nx;
  logic             ram_we, ram_re;
  logic [IDX_W-1:0] ram_raddr;
  logic             hs, len_bad, addr_bad;
  logic [IDX_W-1:0] req_idx;

  assign req_idx   = req_addr[IDX_W-1:0];
  assign hs        = req_valid & req_ready;
  assign len_bad   = (req_len == '0) || (req_len > LEN_W'(MAX_BURST));
  assign addr_bad  = |req_addr[ADDR_W-1:IDX_W];
  assign busy      = (state != IDLE);
  assign req_ready = (state == IDLE);
  assign wr_ready  = (state == WRITE);

  // Reads: beat 1 is fetched on the accept edge; in READ, cnt counts beats
  // still to fetch, so the cycle after the last beat sees cnt==0 and exits.
  // Writes: cnt counts beats still to accept.
  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    cnt_nx      = cnt;
    rd_valid_nx = 1'b0;
    rd_last_nx  = 1'b0;
    err_nx      = 1'b0;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_raddr   = ptr;
    unique case (state)
      IDLE: begin
        if (hs) begin
          err_nx = len_bad | addr_bad;
          if (!len_bad) begin
            if (req_write) begin
              state_nx = WRITE;
              ptr_nx   = req_idx;
              cnt_nx   = req_len;
            end else begin
              state_nx    = READ;
              ram_re      = 1'b1;
              ram_raddr   = req_idx;
              ptr_nx      = req_idx + IDX_W'(1);
              cnt_nx      = req_len - LEN_W'(1);
              rd_valid_nx = 1'b1;
              rd_last_nx  = (req_len == LEN_W'(1));
            end
          end
        end
      end
      READ: begin
        if (cnt != '0) begin
          ram_re      = 1'b1;
          ptr_nx      = ptr + IDX_W'(1);
          cnt_nx      = cnt - LEN_W'(1);
          rd_valid_nx = 1'b1;
          rd_last_nx  = (cnt == LEN_W'(1));
        end else begin
          state_nx = IDLE;
        end
      end
      WRITE: begin
        if (wr_valid) begin
          ram_we = 1'b1;
          ptr_nx = ptr + IDX_W'(1);
          cnt_nx = cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      cnt      <= cnt_nx;
      rd_valid <= rd_valid_nx;
      rd_last  <= rd_last_nx;
      err      <= err_nx;
    end
  end

  dmem_ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (ram_we),
    .waddr      (ptr),
    .wdata      (wr_data),
    .re         (ram_re),
    .raddr      (ram_raddr),
    .rd_data    (rd_data),
    .rd_par_err (rd_par_err)
  );
endmodule

// File: tb/tb_data_memory_burst.sv
// Randomized bench for data_memory_burst: per-cycle expectations derived from
// burst rules (accept at T -> beats T+1..T+len) and an array model of the RAM.
module tb_data_memory_burst;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, wr_valid = 1'b0;
  logic [15:0] req_addr = '0, wr_data = '0;
  logic [3:0]  req_len = '0;
  logic        req_ready, wr_ready, rd_valid, rd_last, busy, err, rd_par_err;
  logic [15:0] rd_data;

  data_memory_burst dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .busy(busy), .err(err), .rd_par_err(rd_par_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  logic [15:0] mem [256];
  bit          exp_busy [int];
  bit          exp_wrr  [int];
  bit          exp_rv   [int];
  logic [15:0] exp_rd   [int];
  bit          exp_rl   [int];
  bit          exp_err  [int];
  bit          exp_pe   [int];
  logic [15:0] last_rd = '0;
  logic [15:0] got [$];
  logic [15:0] wd [8];
  int          pe_beat = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, exp_busy.exists(cyc));
      chk("req_ready", req_ready, !exp_busy.exists(cyc));
      chk("wr_ready", wr_ready, exp_wrr.exists(cyc));
      chk("rd_valid", rd_valid, exp_rv.exists(cyc));
      if (exp_rv.exists(cyc)) last_rd = exp_rd[cyc];
      chk("rd_data", rd_data, last_rd);
      chk("rd_last", rd_last, exp_rl.exists(cyc) ? exp_rl[cyc] : 1'b0);
      chk("err", err, exp_err.exists(cyc));
      chk("rd_par_err", rd_par_err, exp_pe.exists(cyc));
    end
  end

  // Called at the start of a cycle in which the DUT is idle.
  task automatic do_read(input logic [15:0] addr, input int len);
    int T;
    logic [7:0] idx;
    T = cyc;
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_len = 4'(len);
    if (len == 0 || len > 8 || addr[15:8] != 0) exp_err[T+1] = 1'b1;
    idx = addr[7:0];
    if (len >= 1 && len <= 8) begin
      for (int k = 0; k < len; k++) begin
        exp_rv[T+1+k]   = 1'b1;
        exp_rd[T+1+k]   = mem[8'(idx + 8'(k))];
        exp_rl[T+1+k]   = (k == len - 1);
        exp_busy[T+1+k] = 1'b1;
        if (k == pe_beat) exp_pe[T+1+k] = 1'b1;
      end
    end
    step();
    req_valid = 1'b0; req_addr = 16'($urandom);
    got.delete();
    if (len >= 1 && len <= 8) begin
      for (int k = 0; k < len; k++) begin
        @(negedge clk); got.push_back(rd_data);
        @(posedge clk); #1;
      end
    end
  endtask

  // gap_at: -1 no gaps, -2 random gaps, >=0 one gap before that beat.
  task automatic do_write(input logic [15:0] addr, input int len,
                          input logic [15:0] d [8], input int gap_at);
    int k;
    bit gapped;
    logic [7:0] idx;
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_len = 4'(len);
    if (len == 0 || len > 8 || addr[15:8] != 0) exp_err[cyc+1] = 1'b1;
    step();
    req_valid = 1'b0;
    if (len == 0 || len > 8) return;
    idx = addr[7:0]; k = 0; gapped = 1'b0;
    while (k < len) begin
      exp_busy[cyc] = 1'b1;
      exp_wrr[cyc]  = 1'b1;
      if ((k == gap_at && !gapped) || (gap_at == -2 && $urandom_range(0, 3) == 0)) begin
        wr_valid = 1'b0; wr_data = 16'($urandom); gapped = 1'b1;
      end else begin
        wr_valid = 1'b1; wr_data = d[k]; mem[idx] = d[k]; idx++; k++;
      end
      step();
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int r, len;
    logic [15:0] addr;
    // reset state
    step(); step();
    chk("rst_req_ready", req_ready, 1); chk("rst_busy", busy, 0);
    chk("rst_wr_ready", wr_ready, 0);   chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);     chk("rst_rd_data", rd_data, 0);
    chk("rst_err", err, 0);             chk("rst_par", rd_par_err, 0);
    rst_n = 1'b1;
    step();

    // fill the whole RAM so the model is fully known
    for (int b = 0; b < 32; b++) begin
      for (int i = 0; i < 8; i++) wd[i] = 16'($urandom);
      do_write(16'(b * 8), 8, wd, -1);
    end

    // 4-beat write with a gap, immediate read-back
    wd[0] = 16'h00A1; wd[1] = 16'h00A2; wd[2] = 16'h00A3; wd[3] = 16'h00A4;
    do_write(16'h0010, 4, wd, 2);
    do_read(16'h0010, 4);
    chk("lit_a1", got[0], 16'h00A1);
    chk("lit_a4", got[3], 16'h00A4);

    // address wrap
    wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333; wd[3] = 16'h4444;
    do_write(16'h00FE, 4, wd, -1);
    do_read(16'h00FE, 4);
    chk("wrap_ff", got[1], 16'h2222);
    chk("wrap_00", got[2], 16'h3333);

    // illegal lengths leave RAM untouched
    do_read(16'h0010, 0);
    do_read(16'h0010, 9);
    wd[0] = 16'hDEAD;
    do_write(16'h0010, 9, wd, -1);
    do_write(16'h0010, 0, wd, -1);
    do_read(16'h0010, 4);
    chk("illegal_keep", got[0], 16'h00A1);

    // out-of-range upper address bits: err, truncated index still written
    wd[0] = 16'hBEEF;
    do_write(16'h0105, 1, wd, -1);
    do_read(16'h0005, 1);
    chk("trunc_write", got[0], 16'hBEEF);

    // reset during beat 2 of a 4-beat write
    for (int i = 0; i < 4; i++) wd[i] = 16'h0BAD;
    do_write(16'h0040, 4, wd, -1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0040; req_len = 4'd4;
    step();
    req_valid = 1'b0;
    exp_busy[cyc] = 1'b1; exp_wrr[cyc] = 1'b1;
    wr_valid = 1'b1; wr_data = 16'h1234; mem[8'h40] = 16'h1234;
    step();
    wr_data = 16'h5678; rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);       chk("abort_ready", req_ready, 1);
    chk("abort_wr_ready", wr_ready, 0); chk("abort_rd_data", rd_data, 0);
    chk("abort_rd_valid", rd_valid, 0); chk("abort_rd_last", rd_last, 0);
    exp_busy.delete(); exp_wrr.delete(); exp_rv.delete(); exp_rd.delete();
    exp_rl.delete(); exp_err.delete(); exp_pe.delete();
    last_rd = '0;
    step(); step();
    wr_valid = 1'b0; rst_n = 1'b1;
    step();
    do_read(16'h0040, 4);
    chk("abort_beat1", got[0], 16'h1234);
    chk("abort_beat2", got[1], 16'h0BAD);

`ifdef DMEM_PARITY_EN
    wd[0] = 16'h00FF; wd[1] = 16'h0F0F;
    do_write(16'h0020, 2, wd, -1);
    dut.u_ram.mem[32] = dut.u_ram.mem[32] ^ 17'h1;
    mem[8'h20] = mem[8'h20] ^ 16'h1;
    pe_beat = 0;
    do_read(16'h0020, 2);
    pe_beat = -1;
    chk("par_data", got[0], 16'h00FE);
`endif

    // random traffic
    repeat (80) begin
      r = $urandom_range(0, 9);
      addr = {($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 8'($urandom)};
      len = $urandom_range(1, 8);
      if (r == 9) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 15);
      for (int i = 0; i < 8; i++) wd[i] = 16'($urandom);
      if (r < 5) do_read(addr, len);
      else do_write(addr, len, wd, -2);
      if ($urandom_range(0, 2) == 0) step();
    end
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
